// File: rtl/mips_pkg.sv
// MIPS decode constants: opcodes, instruction field positions
// and small opcode classification helpers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Opcodes that read rt as an operand (R-type, branches, stores)
    function automatic logic rt_is_src(input logic [5:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE,
            OP_SB, OP_SH, OP_SW: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic imm_zext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// 2R1W register file, register 0 hardwired to zero,
// same-cycle write-back data forwarded onto both read ports.
module reg_file_bypass
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wr_ok;
    logic              w_hit_a;
    logic              w_hit_b;

    assign w_wr_ok = i_we && (i_waddr != '0);
    assign w_hit_a = w_wr_ok && (i_waddr == i_raddr_a);
    assign w_hit_b = w_wr_ok && (i_waddr == i_raddr_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata_a = r_regs[i_raddr_a];
        o_rdata_b = r_regs[i_raddr_b];
        if (w_hit_a) o_rdata_a = i_wdata;
        if (w_hit_b) o_rdata_b = i_wdata;
        if (i_raddr_a == '0) o_rdata_a = '0;
        if (i_raddr_b == '0) o_rdata_b = '0;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS ID stage: decode, register read with bypass, immediate
// extension, load-use hazard detect, registered ID/EX bundle.
module id_stage_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    localparam int REG_AW  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_pc,
    input  logic [31:0]       if_inst,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              flush,
    output logic              stall,
    output logic              id_valid,
    output logic [31:0]       id_pc,
    output logic [DATA_W-1:0] id_rd1,
    output logic [DATA_W-1:0] id_rd2,
    output logic [DATA_W-1:0] id_imm,
    output logic [5:0]        id_op,
    output logic [REG_AW-1:0] id_rs,
    output logic [REG_AW-1:0] id_rt,
    output logic [REG_AW-1:0] id_rd,
    output logic [4:0]        id_shamt,
    output logic [5:0]        id_funct
);

    logic [5:0]        w_op;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [15:0]       w_imm16;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_rt_src;
    logic              w_hazard;
    logic              w_lui;

    assign w_op    = if_inst[OP_MSB:OP_LSB];
    assign w_rs    = REG_AW'(if_inst[RS_MSB:RS_LSB]);
    assign w_rt    = REG_AW'(if_inst[RT_MSB:RT_LSB]);
    assign w_rd    = REG_AW'(if_inst[RD_MSB:RD_LSB]);
    assign w_imm16 = if_inst[IMM_MSB:IMM_LSB];
    assign w_lui   = (w_op == OP_LUI);

    always_comb begin
        w_imm = '0;
        unique case (1'b1)
            imm_zext(w_op): w_imm = DATA_W'(w_imm16);
            w_lui:          w_imm = DATA_W'({w_imm16, 16'h0000});
            default:        w_imm = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
        endcase
    end

    reg_file_bypass #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .i_we      (wb_we),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rd1),
        .o_rdata_b (w_rd2)
    );

    assign w_rt_src = rt_is_src(w_op);
    assign w_hazard = if_valid && ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == w_rs) || (w_rt_src && (ex_rt == w_rt)));
    // Flush still reports stall; IF resolves the redirect itself
    assign stall    = !rst && w_hazard;

    always_ff @(posedge clk) begin
        if (rst || flush || w_hazard) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_rd1   <= '0;
            id_rd2   <= '0;
            id_imm   <= '0;
            id_op    <= '0;
            id_rs    <= '0;
            id_rt    <= '0;
            id_rd    <= '0;
            id_shamt <= '0;
            id_funct <= '0;
        end else begin
            id_valid <= if_valid;
            id_pc    <= if_pc;
            id_rd1   <= w_rd1;
            id_rd2   <= w_rd2;
            id_imm   <= w_imm;
            id_op    <= w_op;
            id_rs    <= w_rs;
            id_rt    <= w_rt;
            id_rd    <= w_rd;
            id_shamt <= if_inst[SH_MSB:SH_LSB];
            id_funct <= if_inst[FN_MSB:FN_LSB];
        end
    end

endmodule
